// File: rtl/neo_sdcmd_queue.sv
// neo_sdcmd_queue
// Sound-command mailbox between the 68K and the Z80 sound CPU, all in the
// CLK_24M domain. 68K commands are queued in a small FIFO; the Z80 sees the
// head byte on its port $x0 read and gets one NMI per queued command, with a
// fixed high gap between NMIs. The Z80's port $xC write is latched as a
// reply byte for the 68K.
//
// Ports:
//   CLK_24M     in   sole clock
//   nRESET      in   asynchronous active-low reset
//   nSDW        in   68K command write strobe (active low), data on M68K_DATA
//   nSDZ80R     in   Z80 port $x0 read strobe (active low); its rise pops
//   nSDZ80W     in   Z80 port $xC write strobe (active low), data on SDD_IN
//   nNMI_SET    in   Z80 port $x8 write strobe; SDA_L4=0 enables, 1 disables
//   SDD_OUT     out  FIFO head, or the last popped byte when empty
//   M68K_REPLY  out  last Z80 reply byte
//   nZ80NMI     out  registered NMI, low while the FSM is in ASSERT
//   CMD_COUNT   out  FIFO occupancy
//   FIFO_FULL   out  occupancy equals DEPTH
//   OVERRUN     out  sticky: a command was dropped because the FIFO was full
//   DBG_STATE   out  FSM state (0 IDLE, 1 ASSERT, 2 GAP)
//
// Handshake: there is no valid/ready pair; each strobe is an asynchronous
// pulse held low for at least 5 clocks. A push is accepted unless the FIFO
// is full with no pop in the same cycle; a pop is only accepted in ASSERT.
module neo_sdcmd_queue #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 48
) (
  input  logic                     CLK_24M,
  input  logic                     nRESET,
  input  logic                     nSDW,
  input  logic [7:0]               M68K_DATA,
  input  logic                     nSDZ80R,
  input  logic                     nSDZ80W,
  input  logic                     nNMI_SET,
  input  logic                     SDA_L4,
  input  logic [7:0]               SDD_IN,
  output logic [7:0]               SDD_OUT,
  output logic [7:0]               M68K_REPLY,
  output logic                     nZ80NMI,
  output logic [$clog2(DEPTH):0]   CMD_COUNT,
  output logic                     FIFO_FULL,
  output logic                     OVERRUN,
  output logic [1:0]               DBG_STATE
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic          nmi_en;
  logic [7:0]    last;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  // Strobe synchronizers: bit 0 nSDW, 1 nSDZ80R, 2 nSDZ80W, 3 nNMI_SET.
  logic [3:0] strb;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] dly;
  logic [3:0] fall;
  logic [3:0] rise;

  assign strb = {nNMI_SET, nSDZ80W, nSDZ80R, nSDW};

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      sync1 <= '1;
      sync2 <= '1;
      dly   <= '1;
    end else begin
      sync1 <= strb;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign fall = ~sync2 & dly;
  assign rise = sync2 & ~dly;

  logic push_ev;
  logic pop;
  logic push_ok;

  assign push_ev = fall[0];
  // CMD_COUNT is never zero in ASSERT; the guard only keeps the pointers sane.
  assign pop     = rise[1] && (state == ASSERT) && (CMD_COUNT != '0);
  // A pop in the same cycle frees an entry, so a push into a full FIFO is kept.
  assign push_ok = push_ev && (!FIFO_FULL || pop);

  assign FIFO_FULL = (CMD_COUNT == CW'(DEPTH));
  assign SDD_OUT   = (CMD_COUNT != '0) ? mem[rd_ptr] : last;
  assign DBG_STATE = state;

  // Storage is deliberately not reset.
  always_ff @(posedge CLK_24M) begin
    if (push_ok) begin
      mem[wr_ptr] <= M68K_DATA;
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      CMD_COUNT  <= '0;
      OVERRUN    <= 1'b0;
      last       <= 8'h00;
      M68K_REPLY <= 8'h00;
      nmi_en     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_ev && !push_ok) begin
        OVERRUN <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   CMD_COUNT <= CMD_COUNT + 1'b1;
        2'b01:   CMD_COUNT <= CMD_COUNT - 1'b1;
        default: CMD_COUNT <= CMD_COUNT;
      endcase
      if (fall[2]) begin
        M68K_REPLY <= SDD_IN;
      end
      // Port $08 (A4=0) enables, port $18 (A4=1) disables.
      if (fall[3]) begin
        nmi_en <= ~SDA_L4;
      end
    end
  end

  // NMI sequencer. nZ80NMI is registered alongside the state so it is low
  // exactly while state is ASSERT.
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      gap_cnt <= '0;
      nZ80NMI <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if ((CMD_COUNT != '0) && nmi_en) begin
            state   <= ASSERT;
            nZ80NMI <= 1'b0;
          end
        end
        ASSERT: begin
          if (pop) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            nZ80NMI <= 1'b1;
          end else if (!nmi_en) begin
            // Command stays queued; it is re-signalled once re-enabled.
            state   <= IDLE;
            nZ80NMI <= 1'b1;
          end
        end
        GAP: begin
          // Leave on the cycle the counter reaches zero, so the line stays
          // high for exactly GAP_CYCLES clocks before the next assertion.
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
          if (gap_cnt <= GW'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          nZ80NMI <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neo_sdcmd_queue.sv
// Directed testbench for neo_sdcmd_queue: reset values, push/NMI latency,
// ordered delivery with NMI gaps, overflow, simultaneous push/pop when full,
// NMI disable during ASSERT, reply latch, and asynchronous reset mid-ASSERT.
module tb_neo_sdcmd_queue;

  logic       clk;
  logic       rst_n;
  logic       n_sdw;
  logic [7:0] m68k_data;
  logic       n_sdz80r;
  logic       n_sdz80w;
  logic       n_nmi_set;
  logic       sda_l4;
  logic [7:0] sdd_in;
  logic [7:0] sdd_out;
  logic [7:0] m68k_reply;
  logic       n_z80nmi;
  logic [2:0] cmd_count;
  logic       fifo_full;
  logic       overrun;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  neo_sdcmd_queue #(.DEPTH(4), .GAP_CYCLES(48)) dut (
    .CLK_24M    (clk),
    .nRESET     (rst_n),
    .nSDW       (n_sdw),
    .M68K_DATA  (m68k_data),
    .nSDZ80R    (n_sdz80r),
    .nSDZ80W    (n_sdz80w),
    .nNMI_SET   (n_nmi_set),
    .SDA_L4     (sda_l4),
    .SDD_IN     (sdd_in),
    .SDD_OUT    (sdd_out),
    .M68K_REPLY (m68k_reply),
    .nZ80NMI    (n_z80nmi),
    .CMD_COUNT  (cmd_count),
    .FIFO_FULL  (fifo_full),
    .OVERRUN    (overrun),
    .DBG_STATE  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    m68k_data = b;
    n_sdw = 1'b0;
    repeat (6) @(negedge clk);
    n_sdw = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic nmi_set(input logic a4);
    @(negedge clk);
    sda_l4 = a4;
    n_nmi_set = 1'b0;
    repeat (6) @(negedge clk);
    n_nmi_set = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Wait for NMI, read port $x0, then measure how long nZ80NMI stays high
  // before the next NMI (returns a large count if none follows).
  task automatic z80_read(input string tag, output logic [7:0] b, output int hi);
    for (int i = 0; i < 200; i++) begin
      if (n_z80nmi == 1'b0) break;
      @(negedge clk);
    end
    check({tag, "_nmi_wait"}, 32'(n_z80nmi), 32'd0);
    b = sdd_out;
    n_sdz80r = 1'b0;
    repeat (6) @(negedge clk);
    n_sdz80r = 1'b1;
    hi = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (n_z80nmi) hi++;
      else if (hi > 0) break;
    end
  endtask

  logic [7:0] rd_b;
  int         rd_hi;
  logic [7:0] exp_q[$];

  initial begin
    rst_n     = 1'b0;
    n_sdw     = 1'b1;
    m68k_data = 8'h00;
    n_sdz80r  = 1'b1;
    n_sdz80w  = 1'b1;
    n_nmi_set = 1'b1;
    sda_l4    = 1'b0;
    sdd_in    = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_nmi", 32'(n_z80nmi), 32'd1);
    check("rst_cnt", 32'(cmd_count), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_sdd", 32'(sdd_out), 32'h00);
    check("rst_reply", 32'(m68k_reply), 32'h00);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Enable NMI, push 0x5A with edge-accurate checks
    nmi_set(1'b0);
    @(negedge clk);
    m68k_data = 8'h5A;
    n_sdw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("push_e2_cnt", 32'(cmd_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("push_e3_cnt", 32'(cmd_count), 32'd1);
    check("push_e3_sdd", 32'(sdd_out), 32'h5A);
    check("push_e3_nmi", 32'(n_z80nmi), 32'd1);
    @(negedge clk);
    check("push_e4_nmi", 32'(n_z80nmi), 32'd0);
    repeat (4) @(negedge clk);
    n_sdw = 1'b1;
    repeat (4) @(negedge clk);

    // Pop with edge-accurate checks
    n_sdz80r = 1'b0;
    repeat (6) @(negedge clk);
    n_sdz80r = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pop_e2_nmi", 32'(n_z80nmi), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("pop_e3_nmi", 32'(n_z80nmi), 32'd1);
    check("pop_e3_cnt", 32'(cmd_count), 32'd0);
    check("pop_e3_last", 32'(sdd_out), 32'h5A);
    check("pop_e3_state", 32'(dbg_state), 32'd2);
    repeat (60) @(negedge clk);

    // Three queued commands, delivered in order with exact gaps
    exp_q = '{8'h11, 8'h22, 8'h33};
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("q3_cnt", 32'(cmd_count), 32'd3);
    for (int k = 0; k < 3; k++) begin
      z80_read("q3", rd_b, rd_hi);
      check("q3_byte", 32'(rd_b), 32'(exp_q.pop_front()));
      if (k < 2) check("q3_gap", 32'(rd_hi), 32'd48);
    end
    check("q3_end_cnt", 32'(cmd_count), 32'd0);
    check("q3_end_sdd", 32'(sdd_out), 32'h33);

    // Overflow with NMI disabled
    nmi_set(1'b1);
    for (int k = 1; k <= 5; k++) push(8'(k));
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_ovr", 32'(overrun), 32'd1);
    check("ovf_cnt", 32'(cmd_count), 32'd4);
    check("ovf_nmi", 32'(n_z80nmi), 32'd1);
    nmi_set(1'b0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int k = 0; k < 4; k++) begin
      z80_read("ovf", rd_b, rd_hi);
      check("ovf_byte", 32'(rd_b), 32'(exp_q.pop_front()));
      if (k < 3) check("ovf_gap", 32'(rd_hi), 32'd48);
    end
    check("ovf_end_cnt", 32'(cmd_count), 32'd0);
    check("ovf_end_sdd", 32'(sdd_out), 32'h04);

    // Full FIFO, push and pop detected in the same cycle
    do_reset();
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    nmi_set(1'b0);
    check("sim_pre_nmi", 32'(n_z80nmi), 32'd0);
    check("sim_pre_head", 32'(sdd_out), 32'hA1);
    n_sdz80r = 1'b0;
    repeat (6) @(negedge clk);
    n_sdz80r = 1'b1;
    m68k_data = 8'hB5;
    n_sdw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sim_cnt", 32'(cmd_count), 32'd4);
    check("sim_ovr", 32'(overrun), 32'd0);
    check("sim_full", 32'(fifo_full), 32'd1);
    repeat (3) @(negedge clk);
    n_sdw = 1'b1;
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    for (int k = 0; k < 4; k++) begin
      z80_read("sim", rd_b, rd_hi);
      check("sim_byte", 32'(rd_b), 32'(exp_q.pop_front()));
    end
    check("sim_end_cnt", 32'(cmd_count), 32'd0);
    check("sim_end_ovr", 32'(overrun), 32'd0);

    // Disable NMI during ASSERT, then re-enable
    push(8'h77);
    check("dis_pre_nmi", 32'(n_z80nmi), 32'd0);
    @(negedge clk);
    sda_l4 = 1'b1;
    n_nmi_set = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dis_e3_nmi", 32'(n_z80nmi), 32'd0);
    @(negedge clk);
    check("dis_e4_nmi", 32'(n_z80nmi), 32'd1);
    check("dis_e4_state", 32'(dbg_state), 32'd0);
    check("dis_e4_cnt", 32'(cmd_count), 32'd1);
    repeat (3) @(negedge clk);
    n_nmi_set = 1'b1;
    repeat (4) @(negedge clk);
    nmi_set(1'b0);
    check("reen_nmi", 32'(n_z80nmi), 32'd0);
    check("reen_state", 32'(dbg_state), 32'd1);

    // Reply latch timing
    @(negedge clk);
    sdd_in = 8'hA5;
    n_sdz80w = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reply_e2", 32'(m68k_reply), 32'h00);
    @(posedge clk);
    @(negedge clk);
    check("reply_e3", 32'(m68k_reply), 32'hA5);
    repeat (4) @(negedge clk);
    n_sdz80w = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset while asserting
    check("arst_pre_nmi", 32'(n_z80nmi), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_nmi", 32'(n_z80nmi), 32'd1);
    check("arst_cnt", 32'(cmd_count), 32'd0);
    check("arst_reply", 32'(m68k_reply), 32'h00);
    check("arst_sdd", 32'(sdd_out), 32'h00);
    check("arst_state", 32'(dbg_state), 32'd0);
    check("arst_full", 32'(fifo_full), 32'd0);
    check("arst_ovr", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_post_nmi", 32'(n_z80nmi), 32'd1);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
